// File: rtl/trig_counter_pkg.sv
// Shared types and helpers for the retriggerable event counter/timer.
package trig_counter_pkg;

  // Widest length the helper handles; counter WIDTH must not exceed this.
  localparam int unsigned MAX_LEN_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_OS_A  = 2'd0,
    MODE_OS_B  = 2'd1,
    MODE_PER_A = 2'd2,
    MODE_PER_B = 2'd3
  } mode_t;

  // Periodic modes reload at the terminal edge instead of returning to idle.
  function automatic logic is_periodic(input mode_t m);
    return (m == MODE_PER_A) || (m == MODE_PER_B);
  endfunction

  // Modes B select len_b, modes A select len_a.
  function automatic logic uses_len_b(input mode_t m);
    return (m == MODE_OS_B) || (m == MODE_PER_B);
  endfunction

  // A programmed length of zero behaves as a single-cycle count.
  function automatic logic [MAX_LEN_W-1:0] eff_len(input logic [MAX_LEN_W-1:0] len);
    return (len == '0) ? MAX_LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/trig_edge_detect.sv
// Trigger conditioning: rising-edge detect or level pass-through.
module trig_edge_detect #(
  parameter bit EDGE_TRIG = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tr,
  output logic start_c
);

  logic tr_q;

  // Previous trigger sample; cleared by reset so a high tr after reset is an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tr_q <= 1'b0;
    end else begin
      tr_q <= tr;
    end
  end

  assign start_c = EDGE_TRIG ? (tr & ~tr_q) : tr;

endmodule

// File: rtl/trig_counter.sv
// Retriggerable event counter/timer with one-shot and periodic modes.
module trig_counter
  import trig_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          RETRIG    = 1'b0,
  parameter bit          EDGE_TRIG = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tr,
  input  logic [1:0]       mode,
  input  logic             stop,
  input  logic [WIDTH-1:0] len_a,
  input  logic [WIDTH-1:0] len_b,
  output logic             cf,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  state_t           state;
  mode_t            mode_q;
  logic [WIDTH-1:0] len_q;

  logic             start_c;
  logic             terminal_c;
  logic [WIDTH-1:0] start_len_c;
  logic [WIDTH-1:0] reload_len_c;

  trig_edge_detect #(
    .EDGE_TRIG(EDGE_TRIG)
  ) u_edge (
    .clk    (clk),
    .reset  (reset),
    .tr     (tr),
    .start_c(start_c)
  );

  // Lengths for a fresh start (incoming mode) and a periodic reload (latched mode).
  always_comb begin
    start_len_c  = WIDTH'(eff_len(MAX_LEN_W'(uses_len_b(mode_t'(mode)) ? len_b : len_a)));
    reload_len_c = WIDTH'(eff_len(MAX_LEN_W'(uses_len_b(mode_q) ? len_b : len_a)));
    terminal_c   = (state == ST_RUN) && (count == len_q - WIDTH'(1));
  end

  // Control FSM, counter and mode/length latches; stop overrides every other event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      mode_q <= MODE_OS_A;
      len_q  <= WIDTH'(1);
      count  <= '0;
      cf     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      cf <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        count <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_c) begin
              state  <= ST_RUN;
              busy   <= 1'b1;
              count  <= '0;
              mode_q <= mode_t'(mode);
              len_q  <= start_len_c;
            end
          end
          ST_RUN: begin
            if (terminal_c) begin
              cf    <= 1'b1;
              count <= '0;
              if (start_c) begin
                mode_q <= mode_t'(mode);
                len_q  <= start_len_c;
              end else if (is_periodic(mode_q)) begin
                len_q <= reload_len_c;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else if (start_c && RETRIG) begin
              count  <= '0;
              mode_q <= mode_t'(mode);
              len_q  <= start_len_c;
            end else begin
              count <= count + WIDTH'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trig_counter.sv
// Scoreboard bench: four DUTs (all RETRIG/EDGE_TRIG combinations) share one stimulus stream.
module tb_trig_counter;

  localparam int unsigned W  = 8;
  localparam int          NI = 4;

  typedef struct packed {
    logic         cf;
    logic         busy;
    logic [W-1:0] count;
  } exp_t;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         tr    = 1'b0;
  logic [1:0]   mode  = 2'd0;
  logic         stop  = 1'b0;
  logic [W-1:0] len_a = '0;
  logic [W-1:0] len_b = '0;

  logic         cf_w    [NI];
  logic         busy_w  [NI];
  logic [W-1:0] count_w [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int eff(input logic [W-1:0] v);
    return (v == '0) ? 1 : int'(v);
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam bit RT = (gi % 2) == 1;
    localparam bit ET = (gi / 2) == 1;

    exp_t       q[$];
    bit         running;
    bit         prev;
    logic [1:0] lat_mode;
    int         lat_l;
    int         t0;
    int         k;

    trig_counter #(
      .WIDTH    (W),
      .RETRIG   (RT),
      .EDGE_TRIG(ET)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .tr   (tr),
      .mode (mode),
      .stop (stop),
      .len_a(len_a),
      .len_b(len_b),
      .cf   (cf_w[gi]),
      .busy (busy_w[gi]),
      .count(count_w[gi])
    );

    // Pending expectations are void once reset hits asynchronously.
    always @(negedge reset) q.delete();

    // Reference model: run segment start edge t0, elapsed = k - t0, cf when elapsed reaches L.
    always @(posedge clk) begin : model
      exp_t e;
      bit   st;
      bit   c;
      k++;
      c = 1'b0;
      if (!reset) begin
        running  = 1'b0;
        prev     = 1'b0;
        lat_mode = 2'd0;
        lat_l    = 1;
      end else begin
        st   = ET ? (tr && !prev) : tr;
        prev = tr;
        if (stop) begin
          running = 1'b0;
        end else if (!running) begin
          if (st) begin
            running  = 1'b1;
            lat_mode = mode;
            lat_l    = eff(mode[0] ? len_b : len_a);
            t0       = k;
          end
        end else if (k - t0 == lat_l) begin
          c = 1'b1;
          if (st) begin
            lat_mode = mode;
            lat_l    = eff(mode[0] ? len_b : len_a);
            t0       = k;
          end else if (lat_mode >= 2'd2) begin
            lat_l = eff(lat_mode[0] ? len_b : len_a);
            t0    = k;
          end else begin
            running = 1'b0;
          end
        end else if (st && RT) begin
          lat_mode = mode;
          lat_l    = eff(mode[0] ? len_b : len_a);
          t0       = k;
        end
      end
      e.cf    = c;
      e.busy  = running;
      e.count = running ? W'(k - t0) : '0;
      q.push_back(e);
    end

    // Monitor: compare registered outputs half a cycle after each edge.
    always @(negedge clk) begin : monitor
      exp_t e;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (cf_w[gi] !== e.cf || busy_w[gi] !== e.busy || count_w[gi] !== e.count) begin
          errors++;
          $display("FAIL outputs inst%0d (retrig=%0d edge=%0d) t=%0t: got cf/busy/count=%b/%b/%0d, expected %b/%b/%0d",
                   gi, RT, ET, $time, cf_w[gi], busy_w[gi], count_w[gi], e.cf, e.busy, e.count);
        end
      end
    end
  end

  task automatic drive(input logic t, input logic [1:0] m, input logic s,
                       input logic [W-1:0] la, input logic [W-1:0] lb);
    @(negedge clk);
    tr    = t;
    mode  = m;
    stop  = s;
    len_a = la;
    len_b = lb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr   = 1'b0;
      stop = 1'b0;
    end
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clk);
    tr   = 1'b0;
    stop = 1'b0;
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (cf_w[i] !== 1'b0 || busy_w[i] !== 1'b0 || count_w[i] !== '0) begin
        errors++;
        $display("FAIL async_reset inst%0d: got cf/busy/count=%b/%b/%0d, expected 0/0/0",
                 i, cf_w[i], busy_w[i], count_w[i]);
      end
    end
    repeat (hold) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    // Power-on reset for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    idle(3);

    // One-shot A, length 5.
    drive(1'b1, 2'd0, 1'b0, W'(5), W'(0));
    idle(8);

    // Periodic B, length 3, shortened to 2 mid-run, then stopped.
    drive(1'b1, 2'd3, 1'b0, W'(5), W'(3));
    idle(4);
    drive(1'b0, 2'd3, 1'b0, W'(5), W'(2));
    idle(6);
    drive(1'b0, 2'd3, 1'b1, W'(5), W'(2));
    idle(2);

    // Second trigger at e3 during a length-6 one-shot.
    drive(1'b1, 2'd0, 1'b0, W'(6), W'(2));
    idle(2);
    drive(1'b1, 2'd0, 1'b0, W'(6), W'(2));
    idle(10);

    // Stop together with trigger, then reset mid-run.
    drive(1'b1, 2'd2, 1'b0, W'(4), W'(2));
    idle(1);
    drive(1'b1, 2'd2, 1'b1, W'(4), W'(2));
    idle(5);
    drive(1'b1, 2'd2, 1'b0, W'(4), W'(2));
    idle(2);
    pulse_reset(2);
    idle(3);

    // Trigger held high for ten cycles, then zero length.
    for (int i = 0; i < 10; i++) drive(1'b1, 2'd0, 1'b0, W'(3), W'(2));
    idle(5);
    drive(1'b1, 2'd0, 1'b0, W'(0), W'(2));
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulse_reset(int'($urandom_range(1, 2)));
      end else begin
        drive(1'($urandom_range(0, 3) == 0),
              2'($urandom_range(0, 3)),
              1'($urandom_range(0, 39) == 0),
              ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 9)),
              ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 9)));
      end
    end
    idle(4);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trig_counter.md
# trig_counter

Parametrised, retriggerable event counter/timer: a trigger starts a count of a runtime-programmable length, and the block raises a one-cycle completion flag `cf` when the count ends. It generalises the fixed-length, two-mode trigger counter with a configurable width and two runtime lengths. It adds one-shot and periodic modes, optional retrigger and trigger edge detection, an abort input, and count/busy visibility. It sits between control logic that issues triggers and downstream logic consuming `cf` as a timing tick.

## Interface
- `WIDTH`, 8: counter and length width in bits.
- `RETRIG`, 0: 1 = a trigger while running restarts the count; 0 = such a trigger is ignored.
- `EDGE_TRIG`, 0: 1 = start on a rising edge of `tr`; 0 = `tr` sampled as a level.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tr`  in  1  trigger.
- `mode`  in  2  run mode, latched at trigger (see Operation).
- `stop`  in  1  synchronous abort.
- `len_a`  in  WIDTH  length A, in cycles.
- `len_b`  in  WIDTH  length B, in cycles.
- `cf`  out  1  completion flag, one-cycle registered pulse.
- `busy`  out  1  high while in RUN.
- `count`  out  WIDTH  current count value.

## Operation
- Modes:
  - 0 = one-shot, length A.
  - 1 = one-shot, length B.
  - 2 = periodic, length A.
  - 3 = periodic, length B.
- Effective length `L` = selected length, except that a length of 0 is treated as 1.
- States: IDLE and RUN.
- IDLE, with a start event: latch `mode` and `L`, set `count`=0, go to RUN.
  - Start event: `tr`=1 when `EDGE_TRIG`=0; `tr` rising edge (`tr` now 1, previous sample 0) when `EDGE_TRIG`=1.
- RUN, with `count`<L-1: `count` increments by 1.
- RUN, with `count`=L-1 (the terminal edge): `cf`=1 for one cycle.
  - One-shot: go to IDLE, `count`=0.
  - Periodic: stay in RUN, `count`=0, and re-sample `L` from the current `len_a`/`len_b`. The latched mode is kept.
- `stop`=1 in any state: go to IDLE, `count`=0, `cf`=0. `stop` has priority over every other event.
- Start event in RUN, not on the terminal edge:
  - `RETRIG`=1: `count`=0, re-latch `mode` and `L`, no `cf`.
  - `RETRIG`=0: ignored.
- Start event on the terminal edge, any `RETRIG` value: `cf`=1, and a new run starts with `count`=0, freshly latched mode/`L`, and `busy` staying 1.
- `mode` and length changes outside start or reload edges have no effect.
- `count` never exceeds L-1; no wrap-around at 2^WIDTH is possible.
- Reset asserted at any time, including mid-run: IDLE immediately, all outputs 0, edge-detect history cleared to 0.

## Timing
- Reset values: `cf`=0, `busy`=0, `count`=0, state IDLE, latched mode 0, latched `L`=1.
- Start event sampled at edge e0:
  - After e0: `busy`=1, `count`=0.
  - After e(L-1): `count`=L-1.
  - After eL: `cf`=1 for exactly one cycle. In one-shot, `busy` falls on the same edge.
- Trigger-to-`cf` latency is L cycles. The periodic `cf` period is L cycles.
- `L`=1: `cf` is asserted on the edge after the start. In periodic mode `cf` is then asserted on every cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `trig_counter_pkg`:
  - State encodings `ST_IDLE`, `ST_RUN`.
  - Mode codes `MODE_OS_A`, `MODE_OS_B`, `MODE_PER_A`, `MODE_PER_B`.
  - Helper function for effective length (0 maps to 1).
- Sub-module `trig_edge_detect`: registered rising-edge detector with a bypass controlled by `EDGE_TRIG`; asynchronous active-low reset.
- Counter, FSM and latches live in `trig_counter`.

## Test plan
- Reset held low for 2 cycles, then released: `cf`=0, `busy`=0, `count`=0 throughout.
- Mode 0, `len_a`=5, `tr` high for 1 cycle at e0: `count` 0..4, `cf` pulse after e5, `busy` low after e5, no further `cf`.
- Mode 3, `len_b`=3: `cf` after e3, e6 and e9. `len_b` changed to 2 after e4: next `cf` at e6, then period 2 (e8).
- `RETRIG`=1, mode 0, `len_a`=6, second `tr` at e3: `count` back to 0 after e3, `cf` after e9 only. With `RETRIG`=0: `cf` after e6 only.
- Mode 2, `len_a`=4, `stop`=1 at e2 together with `tr`: IDLE after e2, no `cf`. `reset` pulsed low mid-run: outputs 0 immediately.
- `EDGE_TRIG`=1, `tr` held high for 10 cycles, mode 0, `len_a`=3: exactly one `cf`, after e3. `len_a`=0: `cf` after e1.
